// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak output path.
package keccak_pkg;

    localparam int unsigned RATE_SHA3_256 = 1088;
    localparam int unsigned RATE_SHAKE128 = 1344;
    localparam int unsigned KECCAK_W      = 32;

    typedef enum logic {
        IDLE,
        SEND
    } out_state_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/keccak_out_shreg.sv
// Parallel-load rate shifter: loads the full rate, shifts right by one word per
// accepted transfer and exposes the lowest word.
module keccak_out_shreg #(
    parameter int unsigned RATE_MAX = 1344,
    parameter int unsigned W        = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic [RATE_MAX-1:0] data_i,
    output logic [W-1:0]        word_o
);

    logic [RATE_MAX-1:0] shreg_q;
    logic [RATE_MAX-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = shreg_q >> W;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign word_o = shreg_q[W-1:0];

endmodule

// File: rtl/keccak_out_unit.sv
// Keccak output unit: captures the rate and streams it out as W-bit words.
// Optional KECCAK_OUT_BSWAP_EN: byte-reverse each emitted word after tail masking.
module keccak_out_unit
    import keccak_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned RATE_MAX = 1344,
    parameter int unsigned SIZE_W   = 11,
    parameter int unsigned CNT_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lo,
    input  logic                output_busy_set,
    input  logic [SIZE_W-1:0]   output_size,
    input  logic [RATE_MAX-1:0] rate_in,
    output logic                output_busy,
    output logic [W-1:0]        dout,
    output logic                dout_valid,
    output logic                dout_last,
    input  logic                dout_ready
);

    localparam int unsigned TAIL_W = $clog2(W);

    out_state_t        state_q;
    logic              busy_q;
    logic              valid_q;
    logic              last_q;
    logic [CNT_W-1:0]  words_q;
    logic [CNT_W-1:0]  words_d;
    logic [TAIL_W-1:0] tail_q;
    logic [TAIL_W-1:0] tail_d;
    int unsigned       size_eff;

    logic              start;
    logic              shift;
    logic [W-1:0]      word0;
    logic [W-1:0]      mask;
    logic [W-1:0]      masked;
    logic [W-1:0]      dout_sw;

    assign start = (state_q == IDLE) && lo && output_busy_set && (output_size != '0);
    assign shift = valid_q && dout_ready;

    keccak_out_shreg #(
        .RATE_MAX (RATE_MAX),
        .W        (W)
    ) u_shreg (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (start),
        .shift_i (shift),
        .data_i  (rate_in),
        .word_o  (word0)
    );

    // Oversized requests clamp to the full rate, so no partial word is left.
    always_comb begin
        size_eff = 32'(output_size);
        tail_d   = TAIL_W'(size_eff % W);
        if (size_eff > RATE_MAX) begin
            size_eff = RATE_MAX;
            tail_d   = '0;
        end
        words_d = CNT_W'(ceil_div(size_eff, W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            words_q <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SEND;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        last_q  <= (words_d == CNT_W'(1));
                        words_q <= words_d;
                        tail_q  <= tail_d;
                    end
                end
                SEND: begin
                    if (dout_ready) begin
                        words_q <= words_q - CNT_W'(1);
                        if (words_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            last_q  <= (words_q == CNT_W'(2));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mask = '1;
        if (last_q && (tail_q != '0)) begin
            mask = (W'(1) << tail_q) - W'(1);
        end
        masked = word0 & mask;
    end

`ifdef KECCAK_OUT_BSWAP_EN
    always_comb begin
        dout_sw = '0;
        for (int unsigned b = 0; b < W / 8; b++) begin
            dout_sw[8*b +: 8] = masked[W-8-8*b +: 8];
        end
    end
`else
    assign dout_sw = masked;
`endif

    assign dout        = valid_q ? dout_sw : '0;
    assign dout_valid  = valid_q;
    assign dout_last   = last_q;
    assign output_busy = busy_q;

endmodule

// File: tb/tb_keccak_out_unit.sv
// Scoreboard bench for keccak_out_unit: stimulus pushes expected words, a monitor pops them.
module tb_keccak_out_unit;

    localparam int unsigned W    = 32;
    localparam int unsigned RATE = 1344;

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              lo = 1'b0;
    logic              output_busy_set = 1'b0;
    logic [10:0]       output_size = '0;
    logic [RATE-1:0]   rate_in = '0;
    logic              output_busy;
    logic [W-1:0]      dout;
    logic              dout_valid;
    logic              dout_last;
    logic              dout_ready = 1'b1;

    int                tests = 0;
    int                fails = 0;
    bit                rdy_rand = 1'b0;
    exp_t              q[$];

    keccak_out_unit #(
        .W        (32),
        .RATE_MAX (1344),
        .SIZE_W   (11),
        .CNT_W    (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lo              (lo),
        .output_busy_set (output_busy_set),
        .output_size     (output_size),
        .rate_in         (rate_in),
        .output_busy     (output_busy),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_last       (dout_last),
        .dout_ready      (dout_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        dout_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: the first min(size,RATE) bits of rate_in, chopped into words, last partial word zero-padded.
    function automatic void push_expected(input logic [RATE-1:0] data, input int unsigned size);
        int unsigned eff;
        int unsigned n;
        logic [W-1:0] w;
        eff = (size > RATE) ? RATE : size;
        n = (eff + W - 1) / W;
        for (int unsigned i = 0; i < n; i++) begin
            w = data[W*i +: W];
            if (i == n - 1 && eff % W != 0) begin
                w = w & (32'hFFFF_FFFF >> (W - eff % W));
            end
`ifdef KECCAK_OUT_BSWAP_EN
            w = {<<8{w}};
`endif
            q.push_back('{d: w, last: (i == n - 1)});
        end
    endfunction

    function automatic logic [RATE-1:0] rand_rate();
        logic [RATE-1:0] r;
        for (int unsigned i = 0; i < RATE / W; i++) begin
            r[W*i +: W] = $urandom;
        end
        return r;
    endfunction

    // Monitor: pops on every handshake and checks hold stability on stalls.
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_dout;
    logic         prev_last;
    exp_t         e;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(dout_valid), 32'd1);
                check("stall_dout", dout, prev_dout);
                check("stall_last", 32'(dout_last), 32'(prev_last));
            end
            if (dout_valid && dout_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h, expected no word", dout);
                end else begin
                    e = q.pop_front();
                    check("word", dout, e.d);
                    check("last", 32'(dout_last), 32'(e.last));
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
        end
    end

    task automatic issue(input logic [RATE-1:0] data, input int unsigned size, input bit model);
        @(posedge clk);
        #1;
        rate_in         = data;
        output_size     = 11'(size);
        lo              = 1'b1;
        output_busy_set = 1'b1;
        if (model && size != 0) push_expected(data, size);
        @(posedge clk);
        #1;
        lo              = 1'b0;
        output_busy_set = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int unsigned n;
        n = 0;
        while ((q.size() != 0 || output_busy) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_done"}, 32'(q.size() == 0 && !output_busy), 32'd1);
        q.delete();
    endtask

    logic [RATE-1:0] pat;
    int unsigned     cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(output_busy), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_last", 32'(dout_last), 32'd0);
        check("rst_dout", dout, 32'd0);
        rst = 1'b1;

        // SHA3-256 digest with latency and busy-release timing.
        for (int unsigned i = 0; i < RATE / W; i++) pat[W*i +: W] = 32'hA500_0000 + i;
        issue(pat, 256, 1'b1);
        check("lat_valid", 32'(dout_valid), 32'd1);
        check("lat_busy", 32'(output_busy), 32'd1);
        check("first_word", dout, pat[31:0]);
        cyc = 0;
        while (output_busy && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("busy_release_cycles", cyc, 32'd8);
        wait_done("sha256");

        // Reset mid-stream after three words.
        issue(rand_rate(), 256, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_busy", 32'(output_busy), 32'd0);
        check("mid_rst_last", 32'(dout_last), 32'd0);
        check("mid_rst_dout", dout, 32'd0);
        check("mid_rst_popped", q.size(), 32'd5);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(output_busy), 32'd0);
        check("post_rst_valid", 32'(dout_valid), 32'd0);

        // Full SHAKE128 block with random backpressure.
        rdy_rand = 1'b1;
        issue(rand_rate(), 1344, 1'b1);
        check("shake_qlen", q.size(), 32'd42);
        wait_done("shake128");

        // Partial tail.
        issue(rand_rate(), 1000, 1'b1);
        check("tail_qlen", q.size(), 32'd32);
        wait_done("tail1000");

        // Zero size: nothing happens.
        issue(rand_rate(), 0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("zero_busy", 32'(output_busy | dout_valid), 32'd0);
        end

        // Lone strobes are ignored.
        @(posedge clk);
        #1;
        lo = 1'b1;
        output_size = 11'd256;
        @(posedge clk);
        #1;
        lo = 1'b0;
        output_busy_set = 1'b1;
        @(posedge clk);
        #1;
        output_busy_set = 1'b0;
        @(negedge clk);
        check("lone_strobe_busy", 32'(output_busy | dout_valid), 32'd0);

        // Load while busy must not disturb the running stream.
        issue(rand_rate(), 256, 1'b1);
        issue(rand_rate(), 1344, 1'b0);
        wait_done("lo_while_busy");

        // Oversized request clamps to the full rate.
        issue(rand_rate(), 2047, 1'b1);
        check("clamp_qlen", q.size(), 32'd42);
        wait_done("size2047");

`ifdef KECCAK_OUT_BSWAP_EN
        rdy_rand = 1'b0;
        pat = '0;
        pat[31:0] = 32'h1122_3344;
        issue(pat, 32, 1'b0);
        check("bswap_word", dout, 32'h4433_2211);
        check("bswap_last", 32'(dout_last), 32'd1);
        repeat (2) @(posedge clk);
        rdy_rand = 1'b1;
`endif

        // Random sizes and data.
        for (int k = 0; k < 12; k++) begin
            issue(rand_rate(), $urandom_range(1, 2047), 1'b1);
            wait_done("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
